num_check: RTL
==============

# num_check

Packet sink and checker at the receiving end of the number-generator traffic path. Accepts AXI-Stream packets delivered by the NoC, checks framing, destination and zero padding, and keeps saturating statistics. Applies a programmable backpressure pattern to exercise the upstream flow control. Sits at the destination node as the consumer of num_gen traffic.

## Interface
- TDATAW, 32, AXI-Stream data width.
- TDESTW, 4, TDEST width.
- TIDW, 2, TID width. TID is accepted and ignored.
- BEATS_PER_PKT, 1, expected beats per packet (≥1).
- NODE_ID, 1, expected TDEST value.
- PAYLOAD_W, 8, payload bits. TDATA[TDATAW-1:PAYLOAD_W] must be zero.
- CNTW, 16, width of every statistics counter.
- READY_PATTERN, 8'hFF, backpressure pattern. Bit i enables TREADY in pattern phase i.
- CLK  in  1  clock; all logic is on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- ENABLE  in  1  allows acceptance of beats.
- CLEAR  in  1  synchronous clear of the statistics.
- AXIS_S_TVALID  in  1  beat valid.
- AXIS_S_TREADY  out  1  registered ready.
- AXIS_S_TDATA  in  TDATAW  beat data.
- AXIS_S_TLAST  in  1  last beat of packet.
- AXIS_S_TID  in  TIDW  ignored.
- AXIS_S_TDEST  in  TDESTW  destination.
- PKT_DONE  out  1  one-cycle pulse when a packet closes.
- PKT_ERR  out  1  valid with PKT_DONE; 1 means the packet had at least one error.
- PKT_CNT  out  CNTW  count of good packets.
- BEAT_CNT  out  CNTW  count of all accepted beats.
- ERR_LEN_CNT  out  CNTW  packets with a length error.
- ERR_DEST_CNT  out  CNTW  packets with a TDEST mismatch.
- ERR_PAD_CNT  out  CNTW  packets with nonzero padding.
- LAST_CSUM  out  PAYLOAD_W  XOR of payloads of the last good packet.

## Operation
- Handshake occurs when TVALID and TREADY are both high. Only handshake beats affect state.
- FSM states:
  - IDLE: no packet open.
  - BODY: packet open.
  - FLUSH: length error seen; remaining beats are discarded until TLAST.
- IDLE transitions on a handshake:
  - TDEST ≠ NODE_ID: set the dest-error flag. The TDEST check applies to the first beat only.
  - Beat count starts at 1.
  - TLAST with BEATS_PER_PKT=1: close the packet.
  - TLAST with BEATS_PER_PKT>1 (short packet): length error, close the packet.
  - No TLAST with BEATS_PER_PKT=1: length error, go to FLUSH.
  - Otherwise: go to BODY.
- BODY transitions on a handshake:
  - Increment the beat count.
  - TLAST before the count reaches BEATS_PER_PKT: length error (short), close.
  - Count reaches BEATS_PER_PKT with TLAST: close.
  - Count reaches BEATS_PER_PKT without TLAST: length error (long), go to FLUSH.
- FLUSH: a TLAST handshake closes the packet.
- Pad check on every accepted beat, including FLUSH: nonzero upper bits set the pad-error flag.
- Checksum: XOR of TDATA[PAYLOAD_W-1:0] over the packet's beats, starting from 0.
- On close:
  - PKT_DONE pulses.
  - PKT_ERR = OR of the error flags.
  - If no error: PKT_CNT increments and LAST_CSUM loads the checksum.
  - Otherwise: each set flag increments its counter by exactly 1.
  - Flags, beat count and checksum clear; return to IDLE.
- BEAT_CNT increments on every handshake.
- All counters saturate at all-ones; they never wrap.
- CLEAR zeroes all counters and LAST_CSUM. FSM state is unaffected. A handshake or close in the same cycle is applied after the clear, so BEAT_CNT=1.
- ENABLE low: TREADY goes low on the next edge. FSM holds and resumes when ENABLE returns.
- RST mid-packet: the packet is discarded and every output returns to its reset value.

## Timing
- Reset values: TREADY=0, PKT_DONE=0, PKT_ERR=0, all counters=0, LAST_CSUM=0, FSM=IDLE, pattern phase=0.
- TREADY(next) = ENABLE & READY_PATTERN[phase]. The phase increments every cycle mod 8, independent of traffic.
- Close effects, at the edge ending the TLAST or FLUSH-ending handshake cycle:
  - PKT_DONE and PKT_ERR are high for exactly the following cycle.
  - Counters and LAST_CSUM are updated at the same edge.
- Back-to-back single-beat packets are sustained at 1 per cycle with READY_PATTERN=8'hFF.

## Structure
- Package num_pkg holds:
  - state enum typedef {IDLE, BODY, FLUSH};
  - the PAYLOAD_W default;
  - the default NODE_ID.
- Sub-module sat_counter (width parameter, inc/clr inputs, saturating) is instantiated once per statistic.

## Test plan
- Single-beat packets with BEATS_PER_PKT=1, NODE_ID=1: 5 beats, TDEST=1, data 0x5,0x9,0x3,0x1,0x7, all TLAST → PKT_CNT=5, BEAT_CNT=5, LAST_CSUM=0x07, five PKT_DONE pulses with PKT_ERR=0.
- Length errors with BEATS_PER_PKT=3:
  - 4 beats with TLAST on the 4th → ERR_LEN_CNT=1; beat 4 flushed; one PKT_DONE with PKT_ERR=1.
  - Then 2 beats with TLAST on the 2nd → ERR_LEN_CNT=2, PKT_CNT=0.
- Dest and pad errors: packet with TDEST=2 and one beat 0x100 → ERR_DEST_CNT=1, ERR_PAD_CNT=1, PKT_CNT=0, LAST_CSUM unchanged.
- Backpressure: READY_PATTERN=8'b0101_0101 with TVALID held high → TREADY toggles every cycle; every beat is counted exactly once; no beat is lost or duplicated.
- Saturation and clear with CNTW=4: 20 good packets → PKT_CNT=15. CLEAR asserted together with a beat handshake → BEAT_CNT=1, PKT_CNT=0.
- Reset mid-packet with BEATS_PER_PKT=3: RST asserted after beat 2 → all outputs are 0 immediately. A following 3-beat packet is counted good, PKT_CNT=1.

Source files
------------

// File: rtl/num_pkg.sv
// Shared types and defaults for the num_gen traffic checker.
package num_pkg;

  typedef enum logic [1:0] {IDLE, BODY, FLUSH} state_e;

  localparam int unsigned PAYLOAD_W_DEF = 8;
  localparam int unsigned NODE_ID_DEF   = 1;

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that clears synchronously, then counts up and sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear first so an increment in the same cycle lands on zero.
  always_comb begin
    cnt_d = clr_i ? '0 : cnt_q;
    if (inc_i && (cnt_d != '1)) cnt_d = cnt_d + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/num_check.sv
// AXI-Stream packet sink: checks framing, destination and zero padding of num_gen
// packets, keeps saturating statistics and drives a patterned TREADY.
module num_check
  import num_pkg::*;
#(
  parameter int unsigned TDATAW        = 32,
  parameter int unsigned TDESTW        = 4,
  parameter int unsigned TIDW          = 2,
  parameter int unsigned BEATS_PER_PKT = 1,
  parameter int unsigned NODE_ID       = NODE_ID_DEF,
  parameter int unsigned PAYLOAD_W     = PAYLOAD_W_DEF,
  parameter int unsigned CNTW          = 16,
  parameter logic [7:0]  READY_PATTERN = 8'hFF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ENABLE,
  input  logic                 CLEAR,
  input  logic                 AXIS_S_TVALID,
  output logic                 AXIS_S_TREADY,
  input  logic [TDATAW-1:0]    AXIS_S_TDATA,
  input  logic                 AXIS_S_TLAST,
  input  logic [TIDW-1:0]      AXIS_S_TID,
  input  logic [TDESTW-1:0]    AXIS_S_TDEST,
  output logic                 PKT_DONE,
  output logic                 PKT_ERR,
  output logic [CNTW-1:0]      PKT_CNT,
  output logic [CNTW-1:0]      BEAT_CNT,
  output logic [CNTW-1:0]      ERR_LEN_CNT,
  output logic [CNTW-1:0]      ERR_DEST_CNT,
  output logic [CNTW-1:0]      ERR_PAD_CNT,
  output logic [PAYLOAD_W-1:0] LAST_CSUM
);

  localparam int unsigned BCW = $clog2(BEATS_PER_PKT + 1);

  state_e               state_q, state_d;
  logic [BCW-1:0]       bcnt_q, bcnt_d;
  logic [PAYLOAD_W-1:0] csum_q, csum_d, last_csum_q;
  logic                 dest_q, dest_d, len_q, len_d, pad_q, pad_d;
  logic [2:0]           phase_q;
  logic                 tready_q, done_q, err_q;
  logic                 hs_c, close_c, bad_c;
  logic                 unused_tid;

  assign unused_tid = ^AXIS_S_TID;
  assign hs_c       = AXIS_S_TVALID & tready_q;

  // Packet framing: every packet closes on its TLAST beat; length problems only flag it.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    csum_d  = csum_q;
    dest_d  = dest_q;
    len_d   = len_q;
    pad_d   = pad_q;
    close_c = 1'b0;
    if (hs_c) begin
      csum_d = csum_q ^ AXIS_S_TDATA[PAYLOAD_W-1:0];
      pad_d  = pad_q | (|AXIS_S_TDATA[TDATAW-1:PAYLOAD_W]);
      case (state_q)
        IDLE: begin
          dest_d = (AXIS_S_TDEST != TDESTW'(NODE_ID));
          bcnt_d = BCW'(1);
          if (AXIS_S_TLAST) begin
            close_c = 1'b1;
            len_d   = (BEATS_PER_PKT > 1);
          end else if (BEATS_PER_PKT == 1) begin
            len_d   = 1'b1;
            state_d = FLUSH;
          end else begin
            state_d = BODY;
          end
        end
        BODY: begin
          bcnt_d = bcnt_q + BCW'(1);
          if (bcnt_d == BCW'(BEATS_PER_PKT)) begin
            if (AXIS_S_TLAST) begin
              close_c = 1'b1;
            end else begin
              len_d   = 1'b1;
              state_d = FLUSH;
            end
          end else if (AXIS_S_TLAST) begin
            len_d   = 1'b1;
            close_c = 1'b1;
          end
        end
        FLUSH:   close_c = AXIS_S_TLAST;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bad_c = dest_d | len_d | pad_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      bcnt_q      <= '0;
      csum_q      <= '0;
      dest_q      <= 1'b0;
      len_q       <= 1'b0;
      pad_q       <= 1'b0;
      phase_q     <= '0;
      tready_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      last_csum_q <= '0;
    end else begin
      phase_q  <= phase_q + 3'd1;
      tready_q <= ENABLE & READY_PATTERN[phase_q];
      done_q   <= close_c;
      err_q    <= close_c & bad_c;
      if (close_c) begin
        state_q <= IDLE;
        bcnt_q  <= '0;
        csum_q  <= '0;
        dest_q  <= 1'b0;
        len_q   <= 1'b0;
        pad_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        bcnt_q  <= bcnt_d;
        csum_q  <= csum_d;
        dest_q  <= dest_d;
        len_q   <= len_d;
        pad_q   <= pad_d;
      end
      if (close_c && !bad_c) last_csum_q <= csum_d;
      else if (CLEAR)        last_csum_q <= '0;
    end
  end

  sat_counter #(.W(CNTW)) u_pkt_cnt (
    .clk(CLK), .rst(RST), .clr_i(CLEAR), .inc_i(close_c & ~bad_c), .cnt_o(PKT_CNT)
  );
  sat_counter #(.W(CNTW)) u_beat_cnt (
    .clk(CLK), .rst(RST), .clr_i(CLEAR), .inc_i(hs_c), .cnt_o(BEAT_CNT)
  );
  sat_counter #(.W(CNTW)) u_len_cnt (
    .clk(CLK), .rst(RST), .clr_i(CLEAR), .inc_i(close_c & len_d), .cnt_o(ERR_LEN_CNT)
  );
  sat_counter #(.W(CNTW)) u_dest_cnt (
    .clk(CLK), .rst(RST), .clr_i(CLEAR), .inc_i(close_c & dest_d), .cnt_o(ERR_DEST_CNT)
  );
  sat_counter #(.W(CNTW)) u_pad_cnt (
    .clk(CLK), .rst(RST), .clr_i(CLEAR), .inc_i(close_c & pad_d), .cnt_o(ERR_PAD_CNT)
  );

  assign AXIS_S_TREADY = tready_q;
  assign PKT_DONE      = done_q;
  assign PKT_ERR       = err_q;
  assign LAST_CSUM     = last_csum_q;

endmodule
